// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART receiver with glitch rejection and parity/framing
// checks, a first-word-fall-through RX FIFO, and a transmitter with
// configurable frame format. Loopback routes the FIFO head to the TX.
module uart_fifo_core #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rs232_rx,
    output logic                          rs232_tx,
    input  logic                          loopback,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int BIT_DIV  = CLK_FREQ / BAUD;
    localparam int HALF_DIV = BIT_DIV / 2;
    localparam int CW       = $clog2(STOP_BITS * BIT_DIV + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_BITS * BIT_DIV - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH_VAL = (AW+1)'(FIFO_DEPTH);
    localparam logic          PAR_EN    = (PARITY != 0);
    localparam logic          PAR_ODD   = (PARITY == 1);

    // Parity bit that makes (data XOR parity) equal 1 for odd, 0 for even.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    typedef enum logic [2:0] {
        RX_WAIT_HIGH, RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser. prime_q marks when the flops hold real line
    // samples rather than their reset value, so a line held low through
    // reset is not mistaken for idle.
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic [1:0] prime_q;
    logic       rx_s;
    logic       primed_s;

    assign rx_s     = sync_q[1];
    assign primed_s = prime_q[1];

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            prime_q <= 2'b00;
        end else begin
            sync_q  <= {sync_q[0], rs232_rx};
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t              rx_state_q, rx_state_d;
    logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
    logic [3:0]             rx_bits_q, rx_bits_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_q, rx_par_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   push_req_s;
    logic                   rx_par_bad_s;

    assign rx_par_bad_s = PAR_EN && (rx_par_q != calc_parity(rx_shift_q));

    // RX state register and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_WAIT_HIGH;
            rx_cnt_q     <= CNT_ZERO;
            rx_bits_q    <= 4'd0;
            rx_shift_q   <= {DATA_BITS{1'b0}};
            rx_par_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bits_q    <= rx_bits_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_q     <= rx_par_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // RX next-state: sample mid-bit, check stop and parity, request push.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bits_d    = rx_bits_q;
        rx_shift_d   = rx_shift_q;
        rx_par_d     = rx_par_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push_req_s   = 1'b0;
        case (rx_state_q)
            RX_WAIT_HIGH: begin
                if (primed_s && rx_s) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_HIGH;
                end
            end
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_LOAD;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_ZERO) begin
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BIT_LOAD;
                        rx_bits_d  = 4'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_ZERO) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    rx_cnt_d   = BIT_LOAD;
                    if (rx_bits_q == LAST_BIT) begin
                        rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bits_d = rx_bits_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == CNT_ZERO) begin
                    rx_par_d   = rx_s;
                    rx_cnt_d   = BIT_LOAD;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_ZERO) begin
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT_HIGH;
                    end else if (rx_par_bad_s) begin
                        parity_err_d = 1'b1;
                        rx_state_d   = RX_IDLE;
                    end else begin
                        push_req_s = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            default: begin
                rx_state_d = RX_WAIT_HIGH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 overrun_q;
    logic                 empty_s, full_s, pop_s, push_ok_s;
    logic                 tx_accept_s;

    assign empty_s   = (count_q == {(AW+1){1'b0}});
    assign full_s    = (count_q == DEPTH_VAL);
    assign pop_s     = !empty_s && (loopback ? tx_accept_s : rx_ready);
    assign push_ok_s = push_req_s && (!full_s || pop_s);

    // FIFO storage; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= rx_shift_q;
        end
    end

    // FIFO pointers, occupancy and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {(AW+1){1'b0}};
            overrun_q <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_q <= count_q + {{AW{1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{AW{1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
            if (push_req_s && !push_ok_s) begin
                overrun_q <= 1'b1;
            end else if (err_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t              tx_state_q, tx_state_d;
    logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
    logic [3:0]             tx_bits_q, tx_bits_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_line_q, tx_line_d;
    logic                   tx_rdy_q;
    logic                   tx_src_valid_s;
    logic [DATA_BITS-1:0]   tx_src_data_s;

    assign tx_src_valid_s = loopback ? !empty_s : tx_valid;
    assign tx_src_data_s  = loopback ? mem_q[rd_ptr_q] : tx_data;
    assign tx_accept_s    = tx_src_valid_s && tx_rdy_q;

    // TX state register, registered line output and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= CNT_ZERO;
            tx_bits_q  <= 4'd0;
            tx_shift_q <= {DATA_BITS{1'b0}};
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_rdy_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bits_q  <= tx_bits_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            tx_rdy_q   <= (tx_state_d == TX_IDLE);
        end
    end

    // TX next-state: hold each bit BIT_DIV cycles; line follows next state.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bits_d  = tx_bits_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_accept_s) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = BIT_LOAD;
                    tx_shift_d = tx_src_data_s;
                    tx_par_d   = calc_parity(tx_src_data_s);
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_ZERO) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = BIT_LOAD;
                    tx_bits_d  = 4'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_ZERO) begin
                    if (tx_bits_q == LAST_BIT) begin
                        tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
                        tx_cnt_d   = PAR_EN ? BIT_LOAD : STOP_LOAD;
                    end else begin
                        tx_bits_d  = tx_bits_q + 4'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_cnt_d   = BIT_LOAD;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == CNT_ZERO) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = STOP_LOAD;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_ZERO) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_shift_d[0];
            TX_PARITY: tx_line_d = tx_par_d;
            default:   tx_line_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rs232_tx   = tx_line_q;
    assign tx_ready   = tx_rdy_q && !loopback;
    assign rx_data    = empty_s ? {DATA_BITS{1'b0}} : mem_q[rd_ptr_q];
    assign rx_valid   = !empty_s && !loopback;
    assign rx_count   = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: 8 data bits, even parity, 1 stop,
// BIT_DIV=10, 4-entry FIFO.
module tb_uart_fifo_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs232_rx = 1'b1;
    logic       rs232_tx;
    logic       loopback = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       err_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int ferr_cyc = 0;
    int perr_cyc = 0;
    int lb_viol = 0;
    logic lb_mon = 1'b0;

    always #5 clk = ~clk;

    uart_fifo_core #(
        .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .rs232_rx(rs232_rx), .rs232_tx(rs232_tx),
        .loopback(loopback), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_count(rx_count), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun), .err_clr(err_clr)
    );

    // Count error pulse cycles and loopback host-stream violations.
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cyc++;
        if (parity_err === 1'b1) perr_cyc++;
        if (lb_mon && (tx_ready !== 1'b0 || rx_valid !== 1'b0)) lb_viol++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one serial frame: start, 8 data LSB first, even parity, stop.
    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_low);
        logic [10:0] bits;
        bits = {~stop_low, (^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rs232_rx = bits[i];
            tick(10);
        end
        rs232_rx = 1'b1;
    endtask

    // Wait (bounded) for a start bit on rs232_tx and sample each bit mid-way.
    task automatic capture_tx(output logic [7:0] d, output logic p, output logic s, output logic ok);
        int w;
        w = 0; ok = 1'b0; d = 8'h00; p = 1'b0; s = 1'b0;
        while (rs232_tx !== 1'b0 && w < 1000) begin
            tick(1);
            w++;
        end
        if (rs232_tx === 1'b0) begin
            ok = 1'b1;
            tick(4);
            if (rs232_tx !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick(10);
                d[i] = rs232_tx;
            end
            tick(10);
            p = rs232_tx;
            tick(10);
            s = rs232_tx;
        end
    endtask

    task automatic test_reset;
        rs232_rx = 1'b0;
        rst = 1'b1;
        tick(5);
        n_cmp++; if (rs232_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", rs232_tx); end
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_cmp++; if ({frame_err, parity_err, overrun} !== 3'b000) begin n_bad++; $display("FAIL reset_errs: got %b want 000", {frame_err, parity_err, overrun}); end
        rst = 1'b0;
        tick(45);
        rs232_rx = 1'b1;
        tick(30);
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL break_no_push: got %0d want 0", rx_count); end
        n_cmp++; if (ferr_cyc !== 0) begin n_bad++; $display("FAIL break_no_ferr: got %0d want 0", ferr_cyc); end
        send_frame(8'h12, 1'b0, 1'b0);
        n_cmp++; if (rx_count !== 3'd1) begin n_bad++; $display("FAIL first_count: got %0d want 1", rx_count); end
        n_cmp++; if (rx_data !== 8'h12) begin n_bad++; $display("FAIL first_data: got %h want 12", rx_data); end
        n_cmp++; if ((ferr_cyc + perr_cyc) !== 0) begin n_bad++; $display("FAIL first_errs: got %0d want 0", ferr_cyc + perr_cyc); end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL first_pop: got %0d want 0", rx_count); end
    endtask

    task automatic test_host_tx;
        logic [10:0] exp_bits;
        int bad_cyc;
        int rdy_hi;
        exp_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
        rdy_hi = 0;
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL tx_ready_idle: got %b want 1", tx_ready); end
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        for (int b = 0; b < 11; b++) begin
            bad_cyc = 0;
            for (int k = 0; k < 10; k++) begin
                if (rs232_tx !== exp_bits[b]) bad_cyc++;
                if (tx_ready !== 1'b0) rdy_hi++;
                tick(1);
            end
            n_cmp++; if (bad_cyc !== 0) begin n_bad++; $display("FAIL tx_bit%0d: got %0d wrong cycles want 0 (level %b)", b, bad_cyc, exp_bits[b]); end
        end
        n_cmp++; if (rdy_hi !== 0) begin n_bad++; $display("FAIL tx_ready_busy: got %0d high cycles want 0", rdy_hi); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL tx_ready_after: got %b want 1", tx_ready); end
        n_cmp++; if (rs232_tx !== 1'b1) begin n_bad++; $display("FAIL tx_idle_after: got %b want 1", rs232_tx); end
    endtask

    task automatic test_rx_hold_glitch;
        int f0, p0;
        send_frame(8'h3C, 1'b0, 1'b0);
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid: got %b want 1", rx_valid); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL hold_data: got %h want 3c", rx_data); end
        f0 = ferr_cyc; p0 = perr_cyc;
        rs232_rx = 1'b0;
        tick(3);
        rs232_rx = 1'b1;
        tick(30);
        n_cmp++; if (rx_count !== 3'd1) begin n_bad++; $display("FAIL glitch_count: got %0d want 1", rx_count); end
        n_cmp++; if ((ferr_cyc - f0) + (perr_cyc - p0) !== 0) begin n_bad++; $display("FAIL glitch_errs: got %0d want 0", (ferr_cyc - f0) + (perr_cyc - p0)); end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL hold_pop: got %0d want 0", rx_count); end
    endtask

    task automatic test_errors;
        int f0, p0;
        f0 = ferr_cyc; p0 = perr_cyc;
        send_frame(8'h77, 1'b0, 1'b1);
        tick(20);
        n_cmp++; if (ferr_cyc - f0 !== 1) begin n_bad++; $display("FAIL ferr_pulse: got %0d cycles want 1", ferr_cyc - f0); end
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL ferr_count: got %0d want 0", rx_count); end
        f0 = ferr_cyc;
        send_frame(8'h01, 1'b1, 1'b0);
        tick(5);
        n_cmp++; if (perr_cyc - p0 !== 1) begin n_bad++; $display("FAIL perr_pulse: got %0d cycles want 1", perr_cyc - p0); end
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL perr_count: got %0d want 0", rx_count); end
        n_cmp++; if (ferr_cyc - f0 !== 0) begin n_bad++; $display("FAIL perr_no_ferr: got %0d want 0", ferr_cyc - f0); end
    endtask

    task automatic test_overrun;
        logic [7:0] exp_d;
        for (int v = 1; v <= 5; v++) begin
            exp_d = 8'(v);
            send_frame(exp_d, 1'b0, 1'b0);
        end
        n_cmp++; if (rx_count !== 3'd4) begin n_bad++; $display("FAIL ovr_count: got %0d want 4", rx_count); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'(i + 1);
            n_cmp++; if (rx_data !== exp_d) begin n_bad++; $display("FAIL ovr_pop%0d: got %h want %h", i, rx_data, exp_d); end
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL ovr_drain: got %0d want 0", rx_count); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_loopback;
        logic [7:0] d0, d1;
        logic p0, s0, ok0, p1, s1, ok1;
        loopback = 1'b1;
        tick(1);
        lb_mon = 1'b1;
        fork
            begin
                send_frame(8'h55, 1'b0, 1'b0);
                send_frame(8'hAA, 1'b0, 1'b0);
            end
            begin
                capture_tx(d0, p0, s0, ok0);
                capture_tx(d1, p1, s1, ok1);
            end
        join
        tick(20);
        lb_mon = 1'b0;
        n_cmp++; if (ok0 !== 1'b1) begin n_bad++; $display("FAIL lb_start0: got %b want 1", ok0); end
        n_cmp++; if ({d0, p0, s0} !== {8'h55, 1'b0, 1'b1}) begin n_bad++; $display("FAIL lb_frame0: got %h/%b/%b want 55/0/1", d0, p0, s0); end
        n_cmp++; if (ok1 !== 1'b1) begin n_bad++; $display("FAIL lb_start1: got %b want 1", ok1); end
        n_cmp++; if ({d1, p1, s1} !== {8'hAA, 1'b0, 1'b1}) begin n_bad++; $display("FAIL lb_frame1: got %h/%b/%b want aa/0/1", d1, p1, s1); end
        n_cmp++; if (lb_viol !== 0) begin n_bad++; $display("FAIL lb_host_off: got %0d cycles want 0", lb_viol); end
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL lb_drain: got %0d want 0", rx_count); end
        loopback = 1'b0;
        tick(1);
    endtask

    task automatic test_midreset;
        send_frame(8'h3C, 1'b0, 1'b0);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(20);
        n_cmp++; if (rs232_tx !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", rs232_tx); end
        rst = 1'b1;
        tick(1);
        n_cmp++; if (rs232_tx !== 1'b1) begin n_bad++; $display("FAIL mid_tx_high: got %b want 1", rs232_tx); end
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL mid_flush: got %0d want 0", rx_count); end
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %b want 0", tx_ready); end
        rst = 1'b0;
        tick(2);
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_back: got %b want 1", tx_ready); end
    endtask

    initial begin
        test_reset();
        test_host_tx();
        test_rx_hold_glitch();
        test_errors();
        test_overrun();
        test_loopback();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
